// File: rtl/edge_timestamp_logger_if.sv
// Event-read bus between the edge logger and its host.
// Carries the monitored bit in, and the FIFO head, flags and pop request.
// master = host/bench side, slave = logger side.
interface edge_timestamp_logger_if #(
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
);
  logic                     q_in;
  logic                     rd_en;
  logic [TS_WIDTH:0]        rd_data;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output q_in, rd_en,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  q_in, rd_en,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/edge_timestamp_logger.sv
// Tags every sampled transition of q_in with a free-running cycle count and queues it in a FWFT FIFO.
// Latency: an event is visible on rd_data/count one cycle after the edge that samples the transition.
// Backpressure: none upstream; with the FIFO full and no pop the event is dropped and overflow sticks.
module edge_timestamp_logger #(
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  edge_timestamp_logger_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                prev_q, prev_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [TS_WIDTH:0]   mem_q [DEPTH];

  logic edge_det;
  logic do_push;
  logic do_pop;
  logic empty_w;
  logic full_w;

  // Flags come only from registered count; push may use the slot a same-cycle pop frees.
  always_comb begin
    empty_w  = (count_q == '0);
    full_w   = (count_q == DEPTH_C);
    edge_det = bus.q_in ^ prev_q;
    do_pop   = bus.rd_en & ~empty_w;
    do_push  = edge_det & (~full_w | do_pop);
    ts_d     = ts_q + TS_WIDTH'(1);
    prev_d   = bus.q_in;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    ovf_d    = ovf_q | (edge_det & full_w & ~do_pop);
  end

  // Control state: timestamp, previous sample, pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      prev_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Event storage; the word carries the new level (edge type) and the pre-increment timestamp.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {bus.q_in, ts_q};
    end
  end

  // Head is masked to zero while empty so stale storage never leaks out after reset.
  assign bus.rd_data  = empty_w ? '0 : mem_q[rd_ptr_q];
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_edge_timestamp_logger.sv
// Bench for edge_timestamp_logger: vector table plus hand sequences, with a scoreboard queue
// holding events expected at the FIFO head in order.
module tb_edge_timestamp_logger;
  localparam int TSW   = 16;
  localparam int TSW2  = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic q_drv, rd_drv, q2_drv;
  logic up_d, up_q, use_up;

  edge_timestamp_logger_if #(.TS_WIDTH(TSW),  .DEPTH(DEPTH)) bus  ();
  edge_timestamp_logger_if #(.TS_WIDTH(TSW2), .DEPTH(DEPTH)) bus2 ();

  edge_timestamp_logger #(.TS_WIDTH(TSW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  edge_timestamp_logger #(.TS_WIDTH(TSW2), .DEPTH(DEPTH)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Upstream flip-flop whose output q feeds the logger in the pairing test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) up_q <= 1'b0;
    else     up_q <= up_d;
  end

  assign bus.q_in   = use_up ? up_q : q_drv;
  assign bus.rd_en  = rd_drv;
  assign bus2.q_in  = q2_drv;
  assign bus2.rd_en = 1'b0;

  // Reference state and scoreboard.
  int               n_pass = 0;
  int               n_chk  = 0;
  int               m_count;
  logic             m_prev;
  logic             m_ovf;
  logic [TSW-1:0]   m_ts;
  logic [TSW:0]     sb[$];

  typedef struct {
    bit rst_b;
    bit d;
    bit rd;
    int exp_count;
    bit exp_full;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Assert reset at a negedge, check reset outputs, release at the next negedge.
  task automatic do_reset(input logic q_at_release);
    @(negedge clk);
    rst    = 1'b1;
    rd_drv = 1'b0;
    #2;
    chk("rst_count",   32'(bus.count),    32'd0);
    chk("rst_empty",   32'(bus.empty),    32'd1);
    chk("rst_full",    32'(bus.full),     32'd0);
    chk("rst_ovf",     32'(bus.overflow), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data),  32'd0);
    sb.delete();
    m_count = 0;
    m_prev  = 1'b0;
    m_ovf   = 1'b0;
    m_ts    = '0;
    @(negedge clk);
    q_drv  = q_at_release;
    q2_drv = 1'b0;
    up_d   = 1'b0;
    rst    = 1'b0;
  endtask

  // One clock: drive at negedge, predict, let the edge pass, check at the following negedge.
  task automatic step(input logic d, input logic rd);
    logic         smp;
    logic         pop;
    logic         edg;
    logic         acc;
    logic [TSW:0] exp_ev;
    q_drv  = d;
    up_d   = d;
    rd_drv = rd;
    smp    = use_up ? up_q : d;
    pop    = rd && (m_count != 0);
    if (pop) begin
      exp_ev = sb.pop_front();
      chk("pop_data", 32'(bus.rd_data), 32'(exp_ev));
    end
    edg = smp ^ m_prev;
    acc = 1'b0;
    if (edg) begin
      if (m_count < DEPTH || pop) begin
        sb.push_back({smp, m_ts});
        acc = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_count = m_count + int'(acc) - int'(pop);
    m_prev  = smp;
    m_ts    = m_ts + 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_drv = 1'b0;
    chk("step_count", 32'(bus.count),    32'(m_count));
    chk("step_empty", 32'(bus.empty),    32'(m_count == 0));
    chk("step_full",  32'(bus.full),     32'(m_count == DEPTH));
    chk("step_ovf",   32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    q_drv  = 1'b0;
    rd_drv = 1'b0;
    q2_drv = 1'b0;
    up_d   = 1'b0;
    use_up = 1'b0;

    // Fill-and-overflow then drain; then full with simultaneous read, then drain.
    for (int i = 0; i < 9; i++)
      tbl.push_back('{rst_b: (i == 0), d: (i % 2 == 0), rd: 1'b0,
                      exp_count: (i < 8) ? i + 1 : 8, exp_full: (i >= 7), exp_ovf: (i == 8)});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{rst_b: 1'b0, d: 1'b1, rd: 1'b1,
                      exp_count: 7 - i, exp_full: 1'b0, exp_ovf: 1'b1});
    tbl.push_back('{rst_b: 1'b0, d: 1'b1, rd: 1'b1, exp_count: 0, exp_full: 1'b0, exp_ovf: 1'b1});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{rst_b: (i == 0), d: (i % 2 == 0), rd: 1'b0,
                      exp_count: i + 1, exp_full: (i == 7), exp_ovf: 1'b0});
    tbl.push_back('{rst_b: 1'b0, d: 1'b1, rd: 1'b1, exp_count: 8, exp_full: 1'b1, exp_ovf: 1'b0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{rst_b: 1'b0, d: 1'b1, rd: 1'b1,
                      exp_count: 7 - i, exp_full: 1'b0, exp_ovf: 1'b0});

    // Single edge after three low samples.
    do_reset(1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("single_rd_data", 32'(bus.rd_data),  32'h0001_0003);
    chk("single_count",   32'(bus.count),    32'd1);
    chk("single_ovf",     32'(bus.overflow), 32'd0);

    // Pairing through the upstream flop: d high before edges 2 and 3.
    do_reset(1'b0);
    use_up = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("pair_rise", 32'(bus.rd_data), 32'h0001_0003);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("pair_fall", 32'(bus.rd_data), 32'h0000_0005);
    step(1'b0, 1'b1);
    chk("pair_empty", 32'(bus.empty), 32'd1);
    use_up = 1'b0;

    // Vector table.
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].rst_b) do_reset(1'b0);
      step(tbl[k].d, tbl[k].rd);
      chk($sformatf("tbl[%0d].count", k), 32'(bus.count),    32'(tbl[k].exp_count));
      chk($sformatf("tbl[%0d].full", k),  32'(bus.full),     32'(tbl[k].exp_full));
      chk($sformatf("tbl[%0d].ovf", k),   32'(bus.overflow), 32'(tbl[k].exp_ovf));
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Timestamp wrap on the 4-bit instance: 17 low edges then a rise.
    do_reset(1'b0);
    repeat (17) @(negedge clk);
    q2_drv = 1'b1;
    @(negedge clk);
    chk("wrap_count",   32'(bus2.count),   32'd1);
    chk("wrap_rd_data", 32'(bus2.rd_data), 32'h11);

    // Reset between edges with three events stored.
    do_reset(1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("mid_pre_count", 32'(bus.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_empty", 32'(bus.empty),    32'd1);
    chk("mid_count", 32'(bus.count),    32'd0);
    chk("mid_ovf",   32'(bus.overflow), 32'd0);
    sb.delete();
    m_count = 0;
    m_prev  = 1'b0;
    m_ovf   = 1'b0;
    m_ts    = '0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("mid_first_ev", 32'(bus.rd_data), 32'h0001_0000);
    chk("mid_first_ct", 32'(bus.count),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
